// File: rtl/riscv_display_pkg.sv
// Shared constants for the 7-segment display stage: blank patterns and the
// active-low hex glyph table (bit order {g,f,e,d,c,b,a}).
package riscv_display_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low 7-segment glyph.
module hex_to_seg
  import riscv_display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seven_seg_scanner.sv
// 4-digit multiplexed 7-segment scanner: captures a 32-bit word, shows one
// 16-bit half as hex, one digit per refresh tick with a dark cycle between digits.
module seven_seg_scanner
  import riscv_display_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int REFRESH_HZ    = 1_000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic        value_valid,
  input  logic        half_sel,
  input  logic        enable,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        digit_tick
);

  localparam int DIV = CLK_HZ / REFRESH_HZ;
  localparam int PW  = (DIV < 2) ? 1 : $clog2(DIV);

  generate
    if (DIV < 2) begin : g_div_check
      $error("seven_seg_scanner: CLK_HZ/REFRESH_HZ must be >= 2");
    end
  endgenerate

  logic [PW-1:0] prescaler;
  logic [1:0]    digit_idx;
  logic [31:0]   shadow;
  logic          tick;
  logic [15:0]   half;
  logic [3:0]    nib;
  logic [6:0]    seg_pat;
  logic [3:0]    an_lit;
  logic          blanked;

  assign tick   = (prescaler == PW'(DIV - 1));
  assign half   = half_sel ? shadow[31:16] : shadow[15:0];
  assign nib    = half[{digit_idx, 2'b00} +: 4];
  assign an_lit = ~(4'b0001 << digit_idx);

  // A digit is a leading zero only if it and every more-significant nibble are zero.
  always_comb begin
    blanked = 1'b0;
    if (BLANK_LEADING) begin
      case (digit_idx)
        2'd1:    blanked = (half[15:4]  == 12'h0);
        2'd2:    blanked = (half[15:8]  == 8'h0);
        2'd3:    blanked = (half[15:12] == 4'h0);
        default: blanked = 1'b0;
      endcase
    end
  end

  hex_to_seg u_hex_to_seg (
    .nib (nib),
    .seg (seg_pat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler  <= '0;
      digit_idx  <= 2'd0;
      shadow     <= 32'h0;
      seg        <= SEG_OFF;
      an         <= AN_OFF;
      digit_tick <= 1'b0;
    end else begin
      prescaler  <= tick ? '0 : prescaler + 1'b1;
      digit_tick <= tick;
      if (tick)        digit_idx <= digit_idx + 2'd1;
      if (value_valid) shadow    <= value;
      // Dark on the advance cycle so the old glyph never lights the new anode.
      if (!enable || tick) begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
      end else if (blanked) begin
        an  <= an_lit;
        seg <= SEG_OFF;
      end else begin
        an  <= an_lit;
        seg <= seg_pat;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with DIV=4; one instance per BLANK_LEADING setting.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] value;
  logic        value_valid;
  logic        half_sel;
  logic        enable;
  logic [6:0]  seg_nb, seg_bl;
  logic [3:0]  an_nb, an_bl;
  logic        tick_nb, tick_bl;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seven_seg_scanner #(.CLK_HZ(8), .REFRESH_HZ(2), .BLANK_LEADING(1'b0)) u_nb (
    .clk(clk), .reset(reset), .value(value), .value_valid(value_valid),
    .half_sel(half_sel), .enable(enable), .seg(seg_nb), .an(an_nb), .digit_tick(tick_nb));

  seven_seg_scanner #(.CLK_HZ(8), .REFRESH_HZ(2), .BLANK_LEADING(1'b1)) u_bl (
    .clk(clk), .reset(reset), .value(value), .value_valid(value_valid),
    .half_sel(half_sel), .enable(enable), .seg(seg_bl), .an(an_bl), .digit_tick(tick_bl));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench right after the second reset edge; the next cyc() is edge E1.
  task automatic do_reset();
    reset = 1'b1;
    value_valid = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // Strobes value on edge E1.
  task automatic load(input logic [31:0] v);
    value = v;
    value_valid = 1'b1;
    cyc();
    value_valid = 1'b0;
  endtask

  task automatic test_reset();
    half_sel = 1'b0;
    enable = 1'b1;
    value = 32'h0;
    do_reset();
    checks++;
    if (an_bl !== 4'hF || seg_bl !== 7'h7F || tick_bl !== 1'b0) begin
      failures++;
      $display("FAIL reset_state an=%b seg=%b tick=%b required an=1111 seg=1111111 tick=0", an_bl, seg_bl, tick_bl);
    end
    cyc();
    checks++;
    if (an_bl !== 4'b1110 || seg_bl !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_first_edge an=%b seg=%b required an=1110 seg=1000000", an_bl, seg_bl);
    end
    cyc(); cyc();
    checks++;
    if (tick_bl !== 1'b0) begin
      failures++;
      $display("FAIL tick_before_advance tick=%b required 0", tick_bl);
    end
    cyc();
    checks++;
    if (tick_bl !== 1'b1 || an_bl !== 4'hF) begin
      failures++;
      $display("FAIL advance_edge tick=%b an=%b required tick=1 an=1111", tick_bl, an_bl);
    end
  endtask

  task automatic test_scan_no_blank();
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;
    logic [6:0] exp_s;
    int d;
    exp_seg = '{7'b0001110, 7'b0110000, 7'b0001000, 7'b1111001};
    do_reset();
    load(32'h0000_1A3F);
    for (int n = 2; n <= 17; n++) begin
      cyc();
      d = ((n - 1) / 4) % 4;
      if ((n - 1) % 4 == 3) begin
        exp_an = 4'hF;
        exp_s  = 7'h7F;
      end else begin
        exp_an = ~(4'b0001 << d);
        exp_s  = exp_seg[d];
      end
      checks++;
      if (an_nb !== exp_an || seg_nb !== exp_s) begin
        failures++;
        $display("FAIL scan_1a3f edge=%0d an=%b seg=%b required an=%b seg=%b", n, an_nb, seg_nb, exp_an, exp_s);
      end
    end
  endtask

  task automatic test_leading_blank();
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;
    logic [6:0] exp_s;
    int d;
    exp_seg = '{7'b0100100, 7'b0011001, 7'h7F, 7'h7F};
    do_reset();
    load(32'h0000_0042);
    for (int n = 2; n <= 16; n++) begin
      cyc();
      d = ((n - 1) / 4) % 4;
      if ((n - 1) % 4 == 3) begin
        exp_an = 4'hF;
        exp_s  = 7'h7F;
      end else begin
        exp_an = ~(4'b0001 << d);
        exp_s  = exp_seg[d];
      end
      checks++;
      if (an_bl !== exp_an || seg_bl !== exp_s) begin
        failures++;
        $display("FAIL blank_0042 edge=%0d an=%b seg=%b required an=%b seg=%b", n, an_bl, seg_bl, exp_an, exp_s);
      end
    end
    do_reset();
    load(32'h0);
    cyc();
    checks++;
    if (an_bl !== 4'b1110 || seg_bl !== 7'b1000000) begin
      failures++;
      $display("FAIL zero_digit0 an=%b seg=%b required an=1110 seg=1000000", an_bl, seg_bl);
    end
    cyc(); cyc(); cyc();
    checks++;
    if (an_bl !== 4'b1101 || seg_bl !== 7'h7F) begin
      failures++;
      $display("FAIL zero_digit1 an=%b seg=%b required an=1101 seg=1111111", an_bl, seg_bl);
    end
  endtask

  task automatic test_half_sel();
    logic [6:0] exp_seg [4];
    exp_seg = '{7'b0001110, 7'b0000110, 7'b0000110, 7'b0000011};
    do_reset();
    half_sel = 1'b1;
    load(32'hBEEF_0000);
    cyc();
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (an_bl !== ~(4'b0001 << d) || seg_bl !== exp_seg[d]) begin
        failures++;
        $display("FAIL upper_half digit=%0d an=%b seg=%b required seg=%b", d, an_bl, seg_bl, exp_seg[d]);
      end
      cyc(); cyc(); cyc(); cyc();
    end
    // now at E18: digit 0 lit with F; flip to lower half mid-slot
    half_sel = 1'b0;
    cyc();
    checks++;
    if (an_bl !== 4'b1110 || seg_bl !== 7'b1000000) begin
      failures++;
      $display("FAIL half_toggle an=%b seg=%b required an=1110 seg=1000000", an_bl, seg_bl);
    end
  endtask

  task automatic test_capture_on_tick();
    logic exp_t;
    do_reset();
    value = 32'h0;
    cyc(); cyc(); cyc();
    value = 32'h5;
    value_valid = 1'b1;
    cyc();
    value_valid = 1'b0;
    checks++;
    if (an_bl !== 4'hF) begin
      failures++;
      $display("FAIL tick_capture_dark an=%b required 1111", an_bl);
    end
    for (int i = 0; i < 13; i++) cyc();
    checks++;
    if (an_bl !== 4'b1110 || seg_bl !== 7'b0010010) begin
      failures++;
      $display("FAIL tick_capture an=%b seg=%b required an=1110 seg=0010010", an_bl, seg_bl);
    end
    enable = 1'b0;
    for (int n = 18; n <= 25; n++) begin
      cyc();
      exp_t = (n == 20 || n == 24);
      checks++;
      if (an_bl !== 4'hF || seg_bl !== 7'h7F || tick_bl !== exp_t) begin
        failures++;
        $display("FAIL disabled edge=%0d an=%b seg=%b tick=%b required an=1111 seg=1111111 tick=%b", n, an_bl, seg_bl, tick_bl, exp_t);
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    load(32'h0000_1234);
    for (int i = 0; i < 8; i++) cyc();
    checks++;
    if (an_bl !== 4'b1011 || seg_bl !== 7'b0100100) begin
      failures++;
      $display("FAIL pre_reset_digit2 an=%b seg=%b required an=1011 seg=0100100", an_bl, seg_bl);
    end
    reset = 1'b1;
    cyc();
    checks++;
    if (an_bl !== 4'hF || seg_bl !== 7'h7F || tick_bl !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset an=%b seg=%b tick=%b required an=1111 seg=1111111 tick=0", an_bl, seg_bl, tick_bl);
    end
    reset = 1'b0;
    cyc();
    checks++;
    if (an_bl !== 4'b1110 || seg_bl !== 7'b1000000) begin
      failures++;
      $display("FAIL restart_digit0 an=%b seg=%b required an=1110 seg=1000000", an_bl, seg_bl);
    end
    cyc(); cyc(); cyc(); cyc();
    checks++;
    if (an_bl !== 4'b1101 || seg_bl !== 7'h7F) begin
      failures++;
      $display("FAIL restart_shadow_cleared an=%b seg=%b required an=1101 seg=1111111", an_bl, seg_bl);
    end
  endtask

  initial begin
    reset = 1'b1;
    value = 32'h0;
    value_valid = 1'b0;
    half_sel = 1'b0;
    enable = 1'b1;
    test_reset();
    test_scan_no_blank();
    test_leading_blank();
    test_half_sel();
    test_capture_on_tick();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
